// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module : fp16_pkg
//  Shared FP16 definitions for the multiplier result path. Holds the
//  format field widths, the class-flag bit positions, and the packed
//  result word carried through the output FIFO.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  // Class-flag bit positions within the 6-bit flag vector
  localparam int FLG_SNAN = 5;
  localparam int FLG_QNAN = 4;
  localparam int FLG_INF  = 3;
  localparam int FLG_ZERO = 2;
  localparam int FLG_SUB  = 1;
  localparam int FLG_NORM = 0;
  localparam int FLG_W    = 6;

  typedef struct packed {
    logic [FP_W-1:0]  p;
    logic [FLG_W-1:0] flags;
  } fp16_result_t;

  localparam int RES_W = $bits(fp16_result_t);

endpackage : fp16_pkg
`default_nettype wire

// File: rtl/fp_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module : fp_sync_fifo
//  Single-clock FIFO with an explicit occupancy counter. Full and empty
//  come from the counter, so pointers are allowed to wrap freely.
//  Ports  : clk, rst        clock and synchronous active-high reset
//           push, din       write request and data (ignored when full)
//           pop, dout       read request (ignored when empty) and head data
//           empty, full     occupancy status
//           level           entries currently stored, 0..DEPTH
//  Rev    : 1.0  initial release
// ============================================================================
module fp_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so stale storage never leaks out
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: the occupancy counter decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule : fp_sync_fifo
`default_nettype wire

// File: rtl/fp16_mul_result_stage.sv
`default_nettype none
// ============================================================================
//  Module : fp16_mul_result_stage
//  Registered output stage behind the combinational FP16 multiplier.
//  Buffers product + class flags in a small FIFO with valid/ready on both
//  sides, and keeps sticky class flags and a saturating operation count.
//  Ports  : clk, rst                    clock, synchronous active-high reset
//           in_valid/in_ready           upstream handshake
//           in_p, in_snan..in_norm      product word and class flags
//           out_valid/out_ready         downstream handshake
//           out_p, out_flags            head product and flags
//           sticky_flags, clear_flags   accumulated flags and their clear
//           op_count                    accepted operations (saturating)
//           level                       FIFO occupancy
//  Rev    : 1.0  initial release
// ============================================================================
module fp16_mul_result_stage
  import fp16_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_p,
  input  logic                   in_snan,
  input  logic                   in_qnan,
  input  logic                   in_inf,
  input  logic                   in_zero,
  input  logic                   in_sub,
  input  logic                   in_norm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_p,
  output logic [5:0]             out_flags,
  output logic [5:0]             sticky_flags,
  input  logic                   clear_flags,
  output logic [CNT_W-1:0]       op_count,
  output logic [$clog2(DEPTH):0] level
);

  fp16_result_t in_res;
  fp16_result_t out_res;
  logic         push;
  logic         pop;
  logic         empty;
  logic         full;

  // Flags are packed as received; upstream does not guarantee one-hot
  always_comb begin
    in_res                 = '0;
    in_res.p               = in_p;
    in_res.flags[FLG_SNAN] = in_snan;
    in_res.flags[FLG_QNAN] = in_qnan;
    in_res.flags[FLG_INF]  = in_inf;
    in_res.flags[FLG_ZERO] = in_zero;
    in_res.flags[FLG_SUB]  = in_sub;
    in_res.flags[FLG_NORM] = in_norm;
  end

  // in_ready comes only from registered occupancy, so a full FIFO refuses
  // a push even when the head is popped in the same cycle
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fp_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_res),
    .pop   (pop),
    .dout  (out_res),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign out_p     = out_res.p;
  assign out_flags = out_res.flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
      op_count     <= '0;
    end else begin
      // Clear and accumulate in one step so a pushed entry survives a clear
      sticky_flags <= (clear_flags ? 6'b0 : sticky_flags) |
                      (push ? in_res.flags : 6'b0);
      if (push && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule : fp16_mul_result_stage
`default_nettype wire

// File: tb/tb_fp16_mul_result_stage.sv
`default_nettype none
// ============================================================================
//  Module : tb_fp16_mul_result_stage
//  Directed self-checking bench for fp16_mul_result_stage (DEPTH=2,
//  CNT_W=4 so counter saturation is reachable quickly).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_fp16_mul_result_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_p;
  logic             in_snan, in_qnan, in_inf, in_zero, in_sub, in_norm;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_p;
  logic [5:0]       out_flags;
  logic [5:0]       sticky_flags;
  logic             clear_flags;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       level;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp16_mul_result_stage #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_p         (in_p),
    .in_snan      (in_snan),
    .in_qnan      (in_qnan),
    .in_inf       (in_inf),
    .in_zero      (in_zero),
    .in_sub       (in_sub),
    .in_norm      (in_norm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_p        (out_p),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clear_flags  (clear_flags),
    .op_count     (op_count),
    .level        (level)
  );

  // Advance one clock and sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] p, input logic [5:0] f);
    in_valid = v;
    in_p     = p;
    {in_snan, in_qnan, in_inf, in_zero, in_sub, in_norm} = f;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b0;
    clear_flags = 1'b0;
    drive(1'b0, 16'h0000, 6'b000000);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single push: 1.0*3.0 = 3.0 (16'h4200), normal
    drive(1'b1, 16'h4200, 6'b000001);
    tick();
    drive(1'b0, 16'h0000, 6'b000000);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_p", 32'(out_p), 32'h4200);
    chk("t1_out_flags", 32'(out_flags), 32'b000001);
    chk("t1_op_count", 32'(op_count), 32'd1);
    chk("t1_sticky", 32'(sticky_flags), 32'b000001);
    chk("t1_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_drained_valid", 32'(out_valid), 32'd0);
    chk("t1_drained_p", 32'(out_p), 32'd0);

    // Backpressure: three pushes with out_ready low
    drive(1'b1, 16'h3C00, 6'b000001);
    tick();
    chk("t2_level_a", 32'(level), 32'd1);
    chk("t2_in_ready_a", 32'(in_ready), 32'd1);
    drive(1'b1, 16'h7C00, 6'b001000);
    tick();
    chk("t2_level_b", 32'(level), 32'd2);
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h0000, 6'b000100);
    tick();
    chk("t2_level_held", 32'(level), 32'd2);
    chk("t2_op_count_held", 32'(op_count), 32'd3);
    chk("t2_head_stable", 32'(out_p), 32'h3C00);
    // Full with push and pop together: push refused, level 2 -> 1
    out_ready = 1'b1;
    tick();
    chk("t3_level_pop_only", 32'(level), 32'd1);
    chk("t3_op_count_refused", 32'(op_count), 32'd3);
    chk("t2_order_second", 32'(out_p), 32'h7C00);
    chk("t2_flags_second", 32'(out_flags), 32'b001000);
    chk("t3_in_ready_freed", 32'(in_ready), 32'd1);
    // Retry of the held entry is now accepted
    out_ready = 1'b0;
    tick();
    chk("t3_level_refill", 32'(level), 32'd2);
    chk("t3_op_count_refill", 32'(op_count), 32'd4);
    drive(1'b0, 16'h0000, 6'b000000);
    out_ready = 1'b1;
    tick();
    chk("t2_order_third", 32'(out_p), 32'h0000);
    chk("t2_flags_third", 32'(out_flags), 32'b000100);
    chk("t2_level_third", 32'(level), 32'd1);
    tick();
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_sticky", 32'(sticky_flags), 32'b001101);

    // Push and pop with one entry stored: level stays 1
    out_ready = 1'b0;
    drive(1'b1, 16'h3C00, 6'b000001);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 16'h4000, 6'b000010);
    tick();
    drive(1'b0, 16'h0000, 6'b000000);
    chk("t_mid_level", 32'(level), 32'd1);
    chk("t_mid_out_p", 32'(out_p), 32'h4000);
    chk("t_mid_op_count", 32'(op_count), 32'd6);
    tick();
    chk("t_mid_drained", 32'(level), 32'd0);

    // Clear without a push empties sticky flags
    clear_flags = 1'b1;
    tick();
    chk("t_clear_only", 32'(sticky_flags), 32'd0);

    // sNaN pushed during a clear: exactly the pushed flag remains
    sticky_flags_setup();
    clear_flags = 1'b1;
    drive(1'b1, 16'h7D00, 6'b100000);
    out_ready = 1'b0;
    tick();
    clear_flags = 1'b0;
    drive(1'b0, 16'h0000, 6'b000000);
    chk("t4_sticky", 32'(sticky_flags), 32'b100000);
    chk("t4_out_flags", 32'(out_flags), 32'b100000);
    chk("t4_out_p", 32'(out_p), 32'h7D00);
    chk("t4_op_count", 32'(op_count), 32'd8);
    out_ready = 1'b1;
    tick();

    // Saturation: 7 more pushes reach 15, then 12 more must not wrap
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'(i), 6'b000001);
      tick();
    end
    chk("t5_op_count_max", 32'(op_count), 32'd15);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'(i), 6'b000001);
      tick();
    end
    chk("t5_op_count_sat", 32'(op_count), 32'd15);
    drive(1'b0, 16'h0000, 6'b000000);
    tick();

    // Mid-stream reset with two entries queued and a push pending
    out_ready = 1'b0;
    drive(1'b1, 16'h3C00, 6'b000001);
    tick();
    drive(1'b1, 16'h4400, 6'b000001);
    tick();
    chk("t6_level_pre", 32'(level), 32'd2);
    rst = 1'b1;
    drive(1'b1, 16'h4800, 6'b000001);
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 6'b000000);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_sticky", 32'(sticky_flags), 32'd0);
    chk("t6_op_count", 32'(op_count), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_out_p", 32'(out_p), 32'd0);
    tick();
    chk("t6_op_count_after", 32'(op_count), 32'd0);
    chk("t6_level_after", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Set a non-zero sticky bit first so the clear-with-push case is meaningful
  task automatic sticky_flags_setup();
    clear_flags = 1'b0;
    out_ready   = 1'b1;
    drive(1'b1, 16'h7C00, 6'b001000);
    tick();
    drive(1'b0, 16'h0000, 6'b000000);
    chk("t4_pre_sticky", 32'(sticky_flags), 32'b001000);
    tick();
  endtask

endmodule : tb_fp16_mul_result_stage
`default_nettype wire

// File: doc/fp16_mul_result_stage.md
Name: fp16_mul_result_stage

Overview:
- Registered output stage directly downstream of the combinational FP16 multiplier `mul`.
- Captures each product word `p` and its six class flags into a small FIFO and presents them to the consumer with a valid/ready handshake.
- Keeps sticky class/exception flags and a saturating count of completed operations for status readout.
- Breaks the long combinational multiply path from downstream logic.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  multiplier result present on in_p/in_* this cycle.
- in_ready  output  1  stage can accept; equals !full.
- in_p  input  16  FP16 product from multiplier.
- in_snan  input  1  multiplier sNaN_o.
- in_qnan  input  1  multiplier qNaN_o.
- in_inf  input  1  multiplier infinity_o.
- in_zero  input  1  multiplier zero_o.
- in_sub  input  1  multiplier subnormal_o.
- in_norm  input  1  multiplier normal_o.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head entry.
- out_p  output  16  head product.
- out_flags  output  6  head flags {snan,qnan,inf,zero,sub,norm}.
- sticky_flags  output  6  OR of out_flags of every accepted entry since reset/clear.
- clear_flags  input  1  synchronous clear of sticky_flags.
- op_count  output  CNT_W  accepted operations, saturating.
- level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: out_valid=0, out_p=0, out_flags=0, sticky_flags=0, op_count=0, level=0. Read/write pointers are 0. in_ready=1 in the first cycle after reset.
- Reset asserted mid-stream discards all entries and status. Any in_valid present in the reset cycle is not accepted.
- Push condition: in_valid && in_ready.
- Pop condition: out_valid && out_ready.
- in_ready depends only on registered occupancy. There is no combinational path from out_ready to in_ready.
- Latency: an entry pushed in cycle N is visible at out_* with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Ordering: strict FIFO; entries leave in push order.
- Flags are stored exactly as received. The upstream flags are not guaranteed one-hot, so they are not encoded or prioritised.
- out_p/out_flags stay stable while out_valid && !out_ready.
- out_p/out_flags are 0 when empty.
- Empty:
  - out_valid=0.
  - A pop request is ignored.
  - A simultaneous push makes the entry visible next cycle.
- Full (level==DEPTH):
  - in_ready=0, and a push is refused even if a pop occurs in the same cycle.
  - A pop alone frees a slot, so in_ready=1 next cycle.
- Push and pop in the same cycle when neither empty nor full: level unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- sticky_flags:
  - Each cycle: next = (clear_flags ? 0 : sticky_flags) | (push ? in_flags : 0).
  - A clear in the same cycle as a push leaves exactly the pushed flags set.
- op_count:
  - Increments by 1 on each push.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Unaffected by clear_flags.
- Width rules: level ranges 0..DEPTH. All counters are unsigned.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16 field widths (EXP_W=5, MAN_W=10, BIAS=15).
  - Class-flag bit indices (FLG_SNAN=5 ... FLG_NORM=0).
  - A 22-bit fp16_result typedef {p[15:0], flags[5:0]}.
- One natural sub-module: fp_sync_fifo, a parameterised synchronous FIFO of width 22 and depth DEPTH that provides level.
- The top level adds the handshake wiring, sticky flags and op_count.

Test Plan:
- Reset, then push in_p=16'h4200 (1.0*3.0 result) with in_norm=1 -> cycle+1: out_valid=1, out_p=16'h4200, out_flags=6'b000001, op_count=1, sticky_flags=6'b000001.
- Hold out_ready=0 and push 3 entries (16'h3C00, 16'h7C00 with inf, 16'h0000 with zero) -> first 2 accepted, in_ready=0 at level=2, third held. Then set out_ready=1 -> order 3C00, 7C00, 0000; sticky_flags=6'b001101.
- Full FIFO with simultaneous in_valid and out_ready -> push refused that cycle, level 2->1, next cycle push accepted, level 1->2.
- Push a sNaN result 16'h7D00 with in_snan=1 while clear_flags=1 -> sticky_flags=6'b100000 exactly.
- Preload op_count near saturation by pushing 2^CNT_W+3 entries with CNT_W=4 -> op_count stops at 15.
- Assert rst with 2 entries queued -> next cycle out_valid=0, level=0, sticky_flags=0, op_count=0. The in_valid present during the reset cycle is not counted.
